// File: rtl/scan_chain_ctrl_pkg.sv
// scan_chain_ctrl_pkg: FSM state encoding and default chain length for scan_chain_ctrl
package scan_chain_ctrl_pkg;
    localparam int CHAIN_LEN_DEF = 32;
    typedef enum logic [2:0] {IDLE, LOAD, CAPT, UNLOAD, FIN} state_t;
endpackage

// File: rtl/scan_chain_ctrl_shreg.sv
// scan_chain_ctrl_shreg: parallel-load shift register, shifts toward the MSB with serial input at bit 0
module scan_chain_ctrl_shreg #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK) begin
        if (!RN) q <= '0;
        else if (load) q <= din;
        else if (shift) q <= {q[W-2:0], sin};
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: scan load/capture/unload sequencer; SCAN_CHAIN_CTRL_CMP_EN adds EXP_IN/FAIL compare
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP_OUT
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    output logic                 FAIL
`endif
);
    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [CHAIN_LEN-1:0] q;
    logic [CHAIN_LEN-1:0] resp;
    logic go;
    assign go = state == IDLE && START;
    assign resp = {q[CHAIN_LEN-2:0], SO};
    // One register serves both directions: it streams the pattern out while LOAD shifts SO in,
    // so after UNLOAD it holds the response; the MSB of PAT_IN goes straight to SI.
    scan_chain_ctrl_shreg #(.W(CHAIN_LEN)) u_shreg (
        .CLK  (CLK),
        .RN   (RN),
        .load (go),
        .din  ({PAT_IN[CHAIN_LEN-2:0], 1'b0}),
        .shift(state == LOAD || state == UNLOAD),
        .sin  (SO),
        .q    (q)
    );
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state    <= IDLE;
            cnt      <= '0;
            SE       <= 1'b0;
            SI       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESP_OUT <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    state <= LOAD;
                    cnt   <= LAST;
                    SE    <= 1'b1;
                    SI    <= PAT_IN[CHAIN_LEN-1];
                    BUSY  <= 1'b1;
                end
                LOAD: begin
                    SI <= (cnt == '0) ? 1'b0 : q[CHAIN_LEN-1];
                    if (cnt == '0) begin
                        state <= CAPT;
                        SE    <= 1'b0;
                    end else cnt <= cnt - 1'b1;
                end
                CAPT: begin
                    state <= UNLOAD;
                    cnt   <= LAST;
                    SE    <= 1'b1;
                end
                UNLOAD: if (cnt == '0) begin
                    state    <= FIN;
                    SE       <= 1'b0;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                    RESP_OUT <= resp;
                end else cnt <= cnt - 1'b1;
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q;
    always_ff @(posedge CLK) begin
        if (!RN) begin
            exp_q <= '0;
            FAIL  <= 1'b0;
        end else if (go) begin
            exp_q <= EXP_IN;
            FAIL  <= 1'b0;
        end else if (state == UNLOAD && cnt == '0) FAIL <= resp != exp_q;
    end
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed and randomized sequences against a cycle-level expectation of the scan protocol
module tb_scan_chain_ctrl;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic rn = 1'b0, start8 = 1'b0, start2 = 1'b0;
    logic [7:0] pat8 = '0, resp8, chain8 = '0, dval8 = '0;
    logic se8, si8, busy8, done8, so8, hold8 = 1'b1;
    logic [1:0] pat2 = '0, resp2, chain2 = '0;
    logic se2, si2, busy2, done2, so2;
    int tests = 0, fails = 0;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [7:0] exp8 = '0;
    logic [1:0] exp2 = '0;
    logic fail8, fail2;
`endif
    scan_chain_ctrl #(.CHAIN_LEN(8)) u8 (
        .CLK(CLK), .RN(rn), .START(start8), .PAT_IN(pat8), .SO(so8),
        .SE(se8), .SI(si8), .BUSY(busy8), .DONE(done8), .RESP_OUT(resp8)
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        , .EXP_IN(exp8), .FAIL(fail8)
`endif
    );
    scan_chain_ctrl #(.CHAIN_LEN(2)) u2 (
        .CLK(CLK), .RN(rn), .START(start2), .PAT_IN(pat2), .SO(so2),
        .SE(se2), .SI(si2), .BUSY(busy2), .DONE(done2), .RESP_OUT(resp2)
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        , .EXP_IN(exp2), .FAIL(fail2)
`endif
    );
    // Scan chains: shift when SE, otherwise capture D (hold Q, or a tied constant)
    always @(posedge CLK) chain8 <= se8 ? {chain8[6:0], si8} : (hold8 ? chain8 : dval8);
    always @(posedge CLK) chain2 <= se2 ? {chain2[0], si2} : chain2;
    assign so8 = chain8[7];
    assign so2 = chain2[1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run8(input logic [7:0] p, input bit hold, input logic [7:0] dv,
                        input logic [7:0] ex, input bit extra, input int rst_c);
        logic [22:0] se_w, busy_w, done_w, si_w, e_se, e_busy, e_done, e_si;
        logic [7:0] got, e_resp;
        logic gf;
        se_w = '0; busy_w = '0; done_w = '0; si_w = '0;
        e_se = '0; e_busy = '0; e_done = '0; e_si = '0;
        got = '0; gf = 1'b0;
        e_resp = hold ? p : dv;
        hold8 = hold; dval8 = dv; pat8 = p;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        exp8 = ex;
`endif
        @(negedge CLK);
        start8 = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge CLK);
            start8 = extra && (c == 3 || c == 18);
            if (rst_c != 0 && c == rst_c + 1) begin
                chk("rst_se", se8, 0);
                chk("rst_busy", busy8, 0);
                chk("rst_done", done8, 0);
                chk("rst_resp", resp8, 0);
                rn = 1'b1;
                start8 = 1'b0;
                return;
            end
            if (c == rst_c) begin
                rn = 1'b0;
                start8 = 1'b1;
            end
            se_w[c] = se8; busy_w[c] = busy8; done_w[c] = done8; si_w[c] = si8;
            if (done8) begin
                got = resp8;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
                gf = fail8;
`endif
            end
            e_se[c] = (c <= 8) || (c >= 10 && c <= 17);
            e_busy[c] = c <= 17;
            e_done[c] = c == 18;
            if (c <= 8) e_si[c] = p[8-c];
        end
        chk("se_wave", se_w, e_se);
        chk("busy_wave", busy_w, e_busy);
        chk("done_wave", done_w, e_done);
        chk("si_wave", si_w, e_si);
        chk("resp", got, e_resp);
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        chk("fail", gf, e_resp != ex);
`else
        if (gf) chk("fail_absent", gf, 0);
`endif
    endtask

    task automatic run2(input logic [1:0] p);
        int n;
        pat2 = p;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        exp2 = p;
`endif
        @(negedge CLK);
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("n2_latency", n, 6);
        chk("n2_resp", resp2, p);
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        chk("n2_fail", fail2, 0);
`endif
    endtask

    initial begin
        logic [7:0] p, dv, ex;
        bit h;
        repeat (3) @(negedge CLK);
        chk("reset_se", se8, 0);
        chk("reset_si", si8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_resp", resp8, 0);
        chk("reset_resp2", resp2, 0);
        rn = 1'b1;
        run8(8'h5A, 1, 8'h00, 8'h5A, 0, 0);
        run8(8'h00, 0, 8'hA5, 8'hA5, 0, 0);
        run8(8'($urandom), 1, 8'h00, 8'h00, 1, 0);
        run8(8'h3C, 1, 8'h00, 8'h3C, 0, 0);
        run8(8'h3C, 1, 8'h00, 8'h3D, 0, 0);
        run8(8'hC3, 1, 8'h00, 8'hC3, 0, 13);
        run8(8'h96, 1, 8'h00, 8'h96, 0, 0);
        for (int r = 0; r < 6; r++) begin
            p = 8'($urandom);
            dv = 8'($urandom);
            h = 1'($urandom_range(0, 1));
            ex = $urandom_range(0, 1) ? (h ? p : dv) : 8'($urandom);
            run8(p, h, dv, ex, 0, 0);
        end
        run2(2'b10);
        run2(2'b01);
        run2(2'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 32: number of scan flops in the driven chain; legal range 2..1024.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RN  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  one-cycle request to run one load/capture/unload sequence.
REQ-005 PAT_IN  input  CHAIN_LEN  pattern to shift into the chain; bit k targets chain flop k (flop 0 nearest SI).
REQ-006 SO  input  1  Q of the last chain flop (flop CHAIN_LEN-1).
REQ-007 SE  output  1  scan-enable to every chain flop.
REQ-008 SI  output  1  serial data to chain flop 0.
REQ-009 BUSY  output  1  high while a sequence is in progress.
REQ-010 DONE  output  1  one-cycle pulse when RESP_OUT is valid.
REQ-011 RESP_OUT  output  CHAIN_LEN  captured chain contents; bit k = flop k after capture.

Function
REQ-012 FSM states: IDLE, LOAD, CAPT, UNLOAD, FIN; SE, SI, BUSY and DONE shall be registered outputs.
REQ-013 In IDLE, START=1 latches PAT_IN, loads the counter with CHAIN_LEN-1, and enters LOAD; START outside IDLE is ignored.
REQ-014 LOAD: exactly CHAIN_LEN cycles; SE=1; SI presents PAT[CHAIN_LEN-1] in the first cycle, then descending bits down to PAT[0] in the last cycle.
REQ-015 CAPT: exactly one cycle with SE=0 and SI=0; the chain captures functional D at the edge that ends CAPT.
REQ-016 UNLOAD: exactly CHAIN_LEN cycles; SE=1; SI=0; SO sampled at the edge ending unload cycle i is stored to RESP_OUT[CHAIN_LEN-1-i].
REQ-017 FIN: one cycle with DONE=1, BUSY=0 and SE=0, then return to IDLE; START in FIN is ignored.
REQ-018 BUSY=1 in LOAD, CAPT and UNLOAD only; START to first LOAD cycle latency is 1 clock; total sequence is 2*CHAIN_LEN+2 cycles from START to DONE.
REQ-019 The counter shall be $clog2(CHAIN_LEN) bits wide, count down, and the FSM advances when the counter reaches 0 (no wrap-around).
REQ-020 RESP_OUT shall hold its value from FIN until the next UNLOAD updates it.

Reset
REQ-021 RN=0 at a rising edge forces IDLE, counter=0, SE=0, SI=0, BUSY=0, DONE=0, RESP_OUT=0, regardless of state, including mid-LOAD or mid-UNLOAD.
REQ-022 START coincident with RN=0 shall be discarded.

Configuration
REQ-023 Macro SCAN_CHAIN_CTRL_CMP_EN: when defined, adds input EXP_IN[CHAIN_LEN-1:0] (latched with PAT_IN at START) and output FAIL (1 bit).
REQ-024 With SCAN_CHAIN_CTRL_CMP_EN defined, FAIL is valid with DONE and stays valid until the next START: FAIL=1 iff RESP_OUT != EXP_IN latched. FAIL resets to 0.
REQ-025 Without SCAN_CHAIN_CTRL_CMP_EN, neither EXP_IN nor FAIL exists and no compare logic is generated.

Structure
REQ-026 Package scan_chain_ctrl_pkg holds the FSM state enum and the default CHAIN_LEN constant.
REQ-027 One sub-module, scan_chain_ctrl_shreg: a parameterised parallel-load, serial-out/serial-in shift register, used for both PAT and RESP.

Verification
REQ-028 CHAIN_LEN=8. Bench chain of 8 scan flops with D=Q (hold). PAT_IN=8'h5A, START -> DONE exactly 18 cycles after START; RESP_OUT=8'h5A.
REQ-029 Chain D tied to 8'hA5, PAT_IN=8'h00 -> RESP_OUT=8'hA5. The SE waveform is 8 cycles high, 1 low, 8 high, then low.
REQ-030 START pulsed again during LOAD and during FIN -> ignored; only one DONE; BUSY continuous for 17 cycles.
REQ-031 RN=0 during UNLOAD cycle 3 -> next cycle SE=0, BUSY=0, RESP_OUT=0, state IDLE. A new START then completes normally.
REQ-032 SCAN_CHAIN_CTRL_CMP_EN, hold chain, PAT=8'h3C: EXP=8'h3C -> FAIL=0 with DONE; EXP=8'h3D -> FAIL=1.
REQ-033 CHAIN_LEN=2 boundary, PAT=2'b10, hold chain -> RESP_OUT=2'b10, DONE 6 cycles after START.
